// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timer slice.
//   wdt_state_e  : watchdog FSM state encoding
//   WDT_CNT_W    : default counter / limit width
//   WDT_MIN_HOLD : default minimum high/low width of the timeout level
package wdt_pkg;

    localparam int unsigned WDT_CNT_W    = 32;
    localparam int unsigned WDT_MIN_HOLD = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        FIRED    = 2'd2,
        COOLDOWN = 2'd3
    } wdt_state_e;

endpackage

// File: rtl/wdt_timer_if.sv
// Software-facing signal bundle of the watchdog timer.
//   wdt_en   : level, enables the watchdog
//   wdt_kick : single-cycle pulse, restarts the count
//   cnt_load : single-cycle pulse, captures load_val as the new limit
//   load_val : new limit value
//   wto      : registered timeout level
//   cnt_val  : current counter value
// master = software/control side, slave = watchdog side.
interface wdt_timer_if
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_W = WDT_CNT_W
) ();

    logic             wdt_en;
    logic             wdt_kick;
    logic             cnt_load;
    logic [CNT_W-1:0] load_val;
    logic             wto;
    logic [CNT_W-1:0] cnt_val;

    modport master (
        output wdt_en, wdt_kick, cnt_load, load_val,
        input  wto, cnt_val
    );

    modport slave (
        input  wdt_en, wdt_kick, cnt_load, load_val,
        output wto, cnt_val
    );

endinterface

// File: rtl/wdt_prescaler.sv
// Tick generator for the watchdog counter: one tick every PRESCALE clk cycles.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr   : restarts the prescale period (next tick after PRESCALE cycles)
//   tick  : high on the last cycle of each prescale period
// With PRESCALE=1 the register is always zero and tick folds to constant 1.
module wdt_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = (pre == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clr || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/wdt_timer.sv
// Watchdog timer producing a glitch-free registered timeout level (wto)
// with guaranteed minimum high and low widths, so each timeout crosses a
// downstream synchronizer as exactly one pulse.
//   clk   : clock, all logic on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : software bundle (enable, kick, load, load_val, wto, cnt_val)
// The counter advances on prescaler ticks in ARMED; reaching the limit
// fires. FIRED holds wto for at least MIN_HOLD cycles and until a clear,
// then COOLDOWN holds wto low for exactly MIN_HOLD cycles.
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_W    = WDT_CNT_W,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned MIN_HOLD = WDT_MIN_HOLD
) (
    input  logic        clk,
    input  logic        rst_n,
    wdt_timer_if.slave  bus
);

    localparam int unsigned   HW        = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);

    wdt_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_inc;
    logic [HW-1:0]    hold_cnt;
    logic             clr_pend;
    logic             wto_q;
    logic             tick;
    logic             pre_clr;
    logic             hold_done;
    logic             clr_req;

    // Prescaler only runs undisturbed while ARMED with no restart pending;
    // every other case restarts the period so ARMED entry begins at phase 0.
    assign pre_clr   = (state != ARMED) || bus.cnt_load || bus.wdt_kick || !bus.wdt_en;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign clr_req   = bus.wdt_kick || !bus.wdt_en;

    wdt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wto_q    <= 1'b0;
            cnt      <= '0;
            limit    <= '1;
            hold_cnt <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (bus.cnt_load) begin
                limit <= bus.load_val;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.wdt_en) begin
                        state <= ARMED;
                    end
                end

                // Priority: disable, then restart (load/kick), then tick.
                // This makes a kick or disable on the terminal tick win.
                ARMED: begin
                    if (!bus.wdt_en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (bus.cnt_load || bus.wdt_kick) begin
                        cnt <= '0;
                    end else if (tick && (limit != '0)) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == limit) begin
                            state    <= FIRED;
                            wto_q    <= 1'b1;
                            hold_cnt <= '0;
                            clr_pend <= 1'b0;
                        end
                    end
                end

                // A clear arriving on the edge the hold expires is honoured
                // directly, so no extra cycle is spent latching it.
                FIRED: begin
                    if (bus.cnt_load) begin
                        cnt <= '0;
                    end
                    if (hold_done && (clr_pend || clr_req)) begin
                        state    <= COOLDOWN;
                        wto_q    <= 1'b0;
                        cnt      <= '0;
                        hold_cnt <= '0;
                        clr_pend <= 1'b0;
                    end else begin
                        if (!hold_done) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                        if (clr_req) begin
                            clr_pend <= 1'b1;
                        end
                    end
                end

                COOLDOWN: begin
                    cnt <= '0;
                    if (hold_done) begin
                        hold_cnt <= '0;
                        state    <= bus.wdt_en ? ARMED : IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    wto_q <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.wto     = wto_q;
    assign bus.cnt_val = cnt;

endmodule

// File: tb/tb_wdt_timer.sv
module tb_wdt_timer;
    import wdt_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic seen;

    wdt_timer_if #(.CNT_W(32)) if1 ();
    wdt_timer_if #(.CNT_W(32)) if4 ();

    wdt_timer #(.CNT_W(32), .PRESCALE(1), .MIN_HOLD(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    wdt_timer #(.CNT_W(32), .PRESCALE(4), .MIN_HOLD(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if1.wdt_en = 1'b0; if1.wdt_kick = 1'b0; if1.cnt_load = 1'b0; if1.load_val = '0;
        if4.wdt_en = 1'b0; if4.wdt_kick = 1'b0; if4.cnt_load = 1'b0; if4.load_val = '0;

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rst_wto", 32'(if1.wto), 32'd0);
        chk("rst_cnt", if1.cnt_val, 32'd0);
        chk("rst_state", 32'(dut1.state), 32'(IDLE));
        chk("rst_wto_p4", 32'(if4.wto), 32'd0);

        // Load L=5, enable after edge 0 -> wto at edge 6
        if1.load_val = 32'd5; if1.cnt_load = 1'b1;
        step(1);
        if1.cnt_load = 1'b0;
        if1.wdt_en = 1'b1;
        step(5);
        chk("fire_pre_wto", 32'(if1.wto), 32'd0);
        chk("fire_pre_cnt", if1.cnt_val, 32'd4);
        step(1);
        chk("fire_wto", 32'(if1.wto), 32'd1);
        chk("fire_cnt", if1.cnt_val, 32'd5);

        // Early clear: kick one cycle after firing
        if1.wdt_kick = 1'b1;
        step(1);
        if1.wdt_kick = 1'b0;
        chk("hold_f1_wto", 32'(if1.wto), 32'd1);
        chk("hold_f1_cnt", if1.cnt_val, 32'd5);
        step(2);
        chk("hold_f3_wto", 32'(if1.wto), 32'd1);
        step(1);
        chk("clr_f4_wto", 32'(if1.wto), 32'd0);
        chk("clr_f4_cnt", if1.cnt_val, 32'd0);
        step(3);
        chk("cool_c3_wto", 32'(if1.wto), 32'd0);
        chk("cool_c3_state", 32'(dut1.state), 32'(COOLDOWN));
        step(1);
        chk("cool_c4_state", 32'(dut1.state), 32'(ARMED));
        chk("cool_c4_cnt", if1.cnt_val, 32'd0);
        chk("cool_c4_wto", 32'(if1.wto), 32'd0);

        // Kick on the terminal tick, L=3
        if1.load_val = 32'd3; if1.cnt_load = 1'b1;
        step(1);
        if1.cnt_load = 1'b0;
        chk("ld3_cnt", if1.cnt_val, 32'd0);
        step(2);
        chk("ld3_cnt2", if1.cnt_val, 32'd2);
        if1.wdt_kick = 1'b1;
        step(1);
        if1.wdt_kick = 1'b0;
        chk("kterm_wto", 32'(if1.wto), 32'd0);
        chk("kterm_cnt", if1.cnt_val, 32'd0);
        step(2);
        chk("kterm_cnt2", if1.cnt_val, 32'd2);
        if1.wdt_en = 1'b0;
        step(1);
        chk("enterm_wto", 32'(if1.wto), 32'd0);
        chk("enterm_state", 32'(dut1.state), 32'(IDLE));
        chk("enterm_cnt", if1.cnt_val, 32'd0);
        step(3);
        chk("enterm_wto2", 32'(if1.wto), 32'd0);

        // Limit 0: never fires
        if1.load_val = 32'd0; if1.cnt_load = 1'b1;
        step(1);
        if1.cnt_load = 1'b0;
        if1.wdt_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            seen = seen | if1.wto;
        end
        chk("lim0_nofire", 32'(seen), 32'd0);
        chk("lim0_cnt", if1.cnt_val, 32'd0);
        chk("lim0_state", 32'(dut1.state), 32'(ARMED));
        if1.wdt_en = 1'b0;

        // Prescaled kicks: P=4, L=3, kick every 8 cycles
        if4.load_val = 32'd3; if4.cnt_load = 1'b1;
        step(1);
        if4.cnt_load = 1'b0;
        if4.wdt_en = 1'b1;
        step(1);
        chk("p4_armed", 32'(dut4.state), 32'(ARMED));
        seen = 1'b0;
        for (int i = 0; i < 125; i++) begin
            for (int j = 0; j < 8; j++) begin
                if4.wdt_kick = (j == 7);
                step(1);
                seen = seen | if4.wto;
            end
        end
        if4.wdt_kick = 1'b0;
        chk("p4_kicked_nofire", 32'(seen), 32'd0);
        step(11);
        chk("p4_k11_wto", 32'(if4.wto), 32'd0);
        chk("p4_k11_cnt", if4.cnt_val, 32'd2);
        step(1);
        chk("p4_k12_wto", 32'(if4.wto), 32'd1);
        chk("p4_k12_cnt", if4.cnt_val, 32'd3);

        // No clear: wto stays high
        step(20);
        chk("p4_stay_wto", 32'(if4.wto), 32'd1);

        // Asynchronous reset mid-FIRED
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wto", 32'(if4.wto), 32'd0);
        step(2);
        rst_n = 1'b1;
        if4.wdt_en = 1'b0;
        step(1);
        chk("arst_state", 32'(dut4.state), 32'(IDLE));
        chk("arst_cnt", if4.cnt_val, 32'd0);
        chk("arst_wto2", 32'(if4.wto), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
